// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults for the register-file writeback arbiter.
// Queue entries are packed as {RW, BusW}: RW in the upper ADDR_W bits, data below.
package regfile_wb_arbiter_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 4;
  localparam int XZR_IDX    = 31;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// DEPTH x WIDTH result queue with wrap-around pointers and an occupancy count.
// Entries are also exposed oldest-first so the forwarding path can search them.
module regfile_wb_arbiter_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        Clk,
  input  logic                        ResetL,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic [CNT_W-1:0]            count,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            entry_valid
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Index 0 is the head (oldest); higher indices are progressively younger.
  always_comb begin
    entries     = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i]     = mem_q[rd_ptr_q + PTR_W'(i)];
      entry_valid[i] = (CNT_W'(i) < count_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetL) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: ALU results vs queued long-op results onto one regfile write port,
// plus a pending-write scoreboard. Optional forwarding is enabled by defining WB_FORWARD_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = XZR_IDX
) (
  input  logic              Clk,
  input  logic              ResetL,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluRW,
  input  logic [DATA_W-1:0] AluBusW,
  input  logic              MemValid,
  output logic              MemReady,
  input  logic [ADDR_W-1:0] MemRW,
  input  logic [DATA_W-1:0] MemBusW,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueRW,
  input  logic [ADDR_W-1:0] QueryRA,
  input  logic [ADDR_W-1:0] QueryRB,
  output logic              PendA,
  output logic              PendB,
  output logic              RegWr,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  input  logic [ADDR_W-1:0] FwdRA,
  output logic              FwdHit,
  output logic [DATA_W-1:0] FwdData
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int NREGS   = 1 << ADDR_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [ENTRY_W-1:0]            fifo_rdata;
  logic [CNT_W-1:0]              fifo_count;
  logic                          fifo_full, fifo_empty;
  logic [DEPTH-1:0][ENTRY_W-1:0] fifo_entries;
  logic [DEPTH-1:0]              fifo_entry_valid;
  logic                          fifo_push, fifo_pop;
  logic [ADDR_W-1:0]             head_rw;
  logic [DATA_W-1:0]             head_data;
  logic                          alu_win;

  logic              reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] bus_w_q, bus_w_d;
  logic [NREGS-1:0]  sb_q, sb_d;

  regfile_wb_arbiter_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .Clk        (Clk),
    .ResetL     (ResetL),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .wdata      ({MemRW, MemBusW}),
    .rdata      (fifo_rdata),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .entries    (fifo_entries),
    .entry_valid(fifo_entry_valid)
  );

  assign head_rw   = fifo_rdata[DATA_W +: ADDR_W];
  assign head_data = fifo_rdata[DATA_W-1:0];
  assign MemReady  = ResetL && !fifo_full;

  always_comb begin
    alu_win   = AluValid && (AluRW != ZERO_A);
    fifo_pop  = !alu_win && !fifo_empty;
    // XZR long-op results complete the handshake but never occupy a slot.
    fifo_push = MemValid && MemReady && (MemRW != ZERO_A);
    reg_wr_d  = alu_win || fifo_pop;
    rw_d      = rw_q;
    bus_w_d   = bus_w_q;
    if (alu_win) begin
      rw_d    = AluRW;
      bus_w_d = AluBusW;
    end else if (fifo_pop) begin
      rw_d    = head_rw;
      bus_w_d = head_data;
    end
  end

  // Set is applied after clear so a re-issue on the retiring cycle keeps the bit.
  always_comb begin
    sb_d = sb_q;
    if (fifo_pop) begin
      sb_d[head_rw] = 1'b0;
    end
    if (IssueValid && (IssueRW != ZERO_A)) begin
      sb_d[IssueRW] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetL) begin
      reg_wr_q <= 1'b0;
      rw_q     <= '0;
      bus_w_q  <= '0;
      sb_q     <= '0;
    end else begin
      reg_wr_q <= reg_wr_d;
      rw_q     <= rw_d;
      bus_w_q  <= bus_w_d;
      sb_q     <= sb_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (ResetL) begin
      assert (!(alu_win && sb_q[AluRW]));
    end
  end

  assign RegWr = reg_wr_q;
  assign RW    = rw_q;
  assign BusW  = bus_w_q;
  assign PendA = sb_q[QueryRA] && (QueryRA != ZERO_A);
  assign PendB = sb_q[QueryRB] && (QueryRB != ZERO_A);

  logic unused_cnt;
  assign unused_cnt = ^fifo_count;

`ifdef WB_FORWARD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // The register being written this cycle is the oldest candidate; queued entries override it.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (FwdRA != ZERO_A) begin
      if (reg_wr_q && (rw_q == FwdRA)) begin
        fwd_hit  = 1'b1;
        fwd_data = bus_w_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_entry_valid[i] && (fifo_entries[i][DATA_W +: ADDR_W] == FwdRA)) begin
          fwd_hit  = 1'b1;
          fwd_data = fifo_entries[i][DATA_W-1:0];
        end
      end
    end
  end

  assign FwdHit  = fwd_hit;
  assign FwdData = fwd_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{FwdRA, fifo_entries, fifo_entry_valid};
  assign FwdHit     = 1'b0;
  assign FwdData    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued at stimulus time
// and a negedge monitor compares every RegWr pulse against the queue head.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        ResetL;
  logic        AluValid;
  logic [4:0]  AluRW;
  logic [63:0] AluBusW;
  logic        MemValid;
  logic        MemReady;
  logic [4:0]  MemRW;
  logic [63:0] MemBusW;
  logic        IssueValid;
  logic [4:0]  IssueRW;
  logic [4:0]  QueryRA;
  logic [4:0]  QueryRB;
  logic        PendA;
  logic        PendB;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic [4:0]  FwdRA;
  logic        FwdHit;
  logic [63:0] FwdData;

  regfile_wb_arbiter dut (
    .Clk       (Clk),
    .ResetL    (ResetL),
    .AluValid  (AluValid),
    .AluRW     (AluRW),
    .AluBusW   (AluBusW),
    .MemValid  (MemValid),
    .MemReady  (MemReady),
    .MemRW     (MemRW),
    .MemBusW   (MemBusW),
    .IssueValid(IssueValid),
    .IssueRW   (IssueRW),
    .QueryRA   (QueryRA),
    .QueryRB   (QueryRB),
    .PendA     (PendA),
    .PendB     (PendB),
    .RegWr     (RegWr),
    .RW        (RW),
    .BusW      (BusW),
    .FwdRA     (FwdRA),
    .FwdHit    (FwdHit),
    .FwdData   (FwdData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  rw;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic expect_wr(input logic [4:0] rw, input logic [63:0] data);
    wr_t e;
    e.rw   = rw;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (RegWr === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(RW), 64'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_rw", 64'(RW), 64'(e.rw));
        chk("wr_data", BusW, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic [4:0]  mem_rw_v[5]   = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
  logic [63:0] mem_data_v[5] = '{64'h100, 64'h101, 64'h102, 64'h103, 64'h104};
  logic        fwd_en;

  initial begin
`ifdef WB_FORWARD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    ResetL = 1'b0; AluValid = 1'b0; AluRW = '0; AluBusW = '0;
    MemValid = 1'b1; MemRW = 5'd9; MemBusW = 64'h99;
    IssueValid = 1'b1; IssueRW = 5'd9; QueryRA = 5'd9; QueryRB = 5'd0; FwdRA = 5'd0;

    // Reset held with a pending mem result
    repeat (2) begin
      @(negedge Clk);
      chk("rst_regwr", 64'(RegWr), 64'h0);
      chk("rst_memready", 64'(MemReady), 64'h0);
      chk("rst_penda", 64'(PendA), 64'h0);
    end
    chk("rst_rw", 64'(RW), 64'h0);
    chk("rst_busw", BusW, 64'h0);
    step();
    ResetL = 1'b1; MemValid = 1'b0; IssueValid = 1'b0;
    @(negedge Clk);
    chk("post_rst_memready", 64'(MemReady), 64'h1);
    repeat (3) begin
      step();
      @(negedge Clk);
      chk("post_rst_idle", 64'(RegWr), 64'h0);
    end

    // ALU only
    step();
    expect_wr(5'd5, 64'hDEAD);
    AluValid = 1'b1; AluRW = 5'd5; AluBusW = 64'hDEAD;
    step();
    AluValid = 1'b0;
    @(negedge Clk);
    chk("alu_regwr", 64'(RegWr), 64'h1);
    step();
    @(negedge Clk);
    chk("alu_idle_regwr", 64'(RegWr), 64'h0);
    chk("alu_hold_rw", 64'(RW), 64'h5);
    chk("alu_hold_busw", BusW, 64'hDEAD);

    // Contention: ALU busy 6 cycles, 5 long-op results, DEPTH=4
    step();
    for (int i = 0; i < 6; i++) expect_wr(5'(i + 1), 64'hA0 + 64'(i));
    for (int i = 0; i < 5; i++) expect_wr(mem_rw_v[i], mem_data_v[i]);
    begin
      int  mem_idx;
      logic accepted;
      mem_idx = 0;
      for (int cyc = 0; cyc < 30 && mem_idx < 5; cyc++) begin
        AluValid = (cyc < 6);
        AluRW    = 5'(cyc + 1);
        AluBusW  = 64'hA0 + 64'(cyc);
        MemValid = 1'b1;
        MemRW    = mem_rw_v[mem_idx];
        MemBusW  = mem_data_v[mem_idx];
        if (mem_idx == 4 && cyc < 6) chk("full_memready", 64'(MemReady), 64'h0);
        accepted = MemReady;
        step();
        if (accepted) mem_idx++;
      end
      chk("all_mem_accepted", 64'(mem_idx), 64'd5);
    end
    AluValid = 1'b0; MemValid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    chk("contention_drain", 64'(exp_q.size()), 64'h0);
    @(negedge Clk);
    chk("contention_memready", 64'(MemReady), 64'h1);

    // XZR handling
    step();
    AluValid = 1'b1; AluRW = 5'd31; AluBusW = 64'h1;
    MemValid = 1'b1; MemRW = 5'd31; MemBusW = 64'h2;
    IssueValid = 1'b1; IssueRW = 5'd31; QueryRA = 5'd31;
    step();
    AluValid = 1'b0; MemValid = 1'b0; IssueValid = 1'b0;
    @(negedge Clk);
    chk("xzr_regwr", 64'(RegWr), 64'h0);
    chk("xzr_penda", 64'(PendA), 64'h0);
    step();
    @(negedge Clk);
    chk("xzr_not_queued", 64'(RegWr), 64'h0);

    // Scoreboard set/clear, and re-issue on the pop cycle
    step();
    IssueValid = 1'b1; IssueRW = 5'd7; QueryRA = 5'd7; QueryRB = 5'd8;
    step();
    IssueValid = 1'b0;
    @(negedge Clk);
    chk("sb_set_penda", 64'(PendA), 64'h1);
    chk("sb_other_pendb", 64'(PendB), 64'h0);
    step();
    IssueValid = 1'b1; IssueRW = 5'd8;
    step();
    IssueValid = 1'b0;
    @(negedge Clk);
    chk("sb_hold_penda", 64'(PendA), 64'h1);
    chk("sb_set_pendb", 64'(PendB), 64'h1);
    step();
    expect_wr(5'd7, 64'h77);
    MemValid = 1'b1; MemRW = 5'd7; MemBusW = 64'h77;
    step();
    MemValid = 1'b0;
    @(negedge Clk);
    chk("sb_queued_penda", 64'(PendA), 64'h1);
    step();
    @(negedge Clk);
    chk("sb_clear_penda", 64'(PendA), 64'h0);
    chk("sb_keep_pendb", 64'(PendB), 64'h1);
    step();
    IssueValid = 1'b1; IssueRW = 5'd7;
    step();
    IssueValid = 1'b0;
    expect_wr(5'd7, 64'h78);
    MemValid = 1'b1; MemRW = 5'd7; MemBusW = 64'h78;
    step();
    MemValid = 1'b0;
    IssueValid = 1'b1; IssueRW = 5'd7;
    step();
    IssueValid = 1'b0;
    @(negedge Clk);
    chk("sb_reissue_penda", 64'(PendA), 64'h1);
    step();
    expect_wr(5'd7, 64'h79);
    expect_wr(5'd8, 64'h88);
    MemValid = 1'b1; MemRW = 5'd7; MemBusW = 64'h79;
    step();
    MemRW = 5'd8; MemBusW = 64'h88;
    step();
    MemValid = 1'b0;
    step();
    @(negedge Clk);
    chk("sb_final_penda", 64'(PendA), 64'h0);
    chk("sb_final_pendb", 64'(PendB), 64'h0);

    // Forwarding: two queued x3 results behind a busy ALU
    step();
    expect_wr(5'd10, 64'hA10);
    expect_wr(5'd11, 64'hA11);
    expect_wr(5'd12, 64'hA12);
    expect_wr(5'd3, 64'h11);
    expect_wr(5'd3, 64'h22);
    AluValid = 1'b1; AluRW = 5'd10; AluBusW = 64'hA10;
    MemValid = 1'b1; MemRW = 5'd3; MemBusW = 64'h11;
    step();
    AluRW = 5'd11; AluBusW = 64'hA11;
    MemBusW = 64'h22;
    step();
    AluRW = 5'd12; AluBusW = 64'hA12;
    MemValid = 1'b0;
    @(negedge Clk);
    FwdRA = 5'd3;
    #1;
    chk("fwd_q_hit", 64'(FwdHit), 64'(fwd_en));
    chk("fwd_q_youngest", FwdData, fwd_en ? 64'h22 : 64'h0);
    FwdRA = 5'd11;
    #1;
    chk("fwd_port_hit", 64'(FwdHit), 64'(fwd_en));
    chk("fwd_port_data", FwdData, fwd_en ? 64'hA11 : 64'h0);
    FwdRA = 5'd4;
    #1;
    chk("fwd_miss", 64'(FwdHit), 64'h0);
    step();
    AluValid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    chk("fwd_drain", 64'(exp_q.size()), 64'h0);

    // Reset mid-operation drops queued results and pending bits
    step();
    expect_wr(5'd20, 64'h200);
    expect_wr(5'd22, 64'h202);
    AluValid = 1'b1; AluRW = 5'd20; AluBusW = 64'h200;
    MemValid = 1'b1; MemRW = 5'd21; MemBusW = 64'h201;
    IssueValid = 1'b1; IssueRW = 5'd21; QueryRA = 5'd21;
    step();
    IssueValid = 1'b0;
    AluRW = 5'd22; AluBusW = 64'h202;
    MemRW = 5'd23; MemBusW = 64'h203;
    step();
    AluValid = 1'b0; MemValid = 1'b0;
    ResetL = 1'b0;
    step();
    ResetL = 1'b1;
    @(negedge Clk);
    chk("midrst_penda", 64'(PendA), 64'h0);
    repeat (4) begin
      step();
      @(negedge Clk);
      chk("midrst_no_write", 64'(RegWr), 64'h0);
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
